// File: rtl/beam_threshold_loader.sv
// Stages per-beam trigger thresholds and loads only the changed beams, one beam per cycle, then strobes update.
// Latency: first beam load one cycle after the commit is registered. No backpressure: writes made while busy are rejected with wr_err_o.
module beam_threshold_loader #(
    parameter int          NBEAMS         = 2,
    parameter logic [17:0] DEFAULT_THRESH = 18'h3FFFF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en_i,
    input  logic [5:0]        wr_beam_i,
    input  logic [17:0]       wr_thresh_i,
    input  logic              commit_i,
    output logic [17:0]       thresh_o,
    output logic [NBEAMS-1:0] thresh_ce_o,
    output logic              update_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              wr_err_o
);

    localparam logic [5:0] LAST = 6'(NBEAMS - 1);
    localparam logic [6:0] NB7  = 7'(NBEAMS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [5:0]        k, k_nxt;
    logic [17:0]       stage [NBEAMS];
    logic [NBEAMS-1:0] dirty, dirty_nxt, hit, sel, ce_nxt;
    logic              pending, pending_nxt;
    logic              loaded, loaded_nxt;
    logic              wr_ok, emit, last;
    logic [5:0]        emit_beam;
    logic [17:0]       thresh_nxt;

    always_comb begin
        wr_ok = wr_en_i && (state == IDLE) && ({1'b0, wr_beam_i} < NB7);
    end

    // Outputs are registered, so each edge emits the beam the next cycle will show.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        emit      = 1'b0;
        emit_beam = k + 6'd1;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_nxt = SCAN;
                    k_nxt     = 6'd0;
                    emit      = 1'b1;
                    emit_beam = 6'd0;
                end
            end
            SCAN: begin
                if (k == LAST) begin
                    state_nxt = UPDATE;
                    last      = 1'b1;
                end else begin
                    k_nxt = k + 6'd1;
                    emit  = 1'b1;
                end
            end
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A write accepted on the same edge that starts a scan is forwarded to beam 0.
    always_comb begin
        hit        = '0;
        sel        = '0;
        thresh_nxt = thresh_o;
        for (int i = 0; i < NBEAMS; i++) begin
            hit[i] = wr_ok && (wr_beam_i == 6'(i));
            sel[i] = emit && (emit_beam == 6'(i));
        end
        ce_nxt = sel & (dirty | hit);
        for (int i = 0; i < NBEAMS; i++) begin
            if (ce_nxt[i]) begin
                thresh_nxt = hit[i] ? wr_thresh_i : stage[i];
            end
        end
        dirty_nxt   = (dirty | hit) & ~sel;
        loaded_nxt  = ((state == IDLE) ? 1'b0 : loaded) | (|ce_nxt);
        pending_nxt = (state == IDLE && pending) ? 1'b0 : (pending | commit_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            k     <= 6'd0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NBEAMS; i++) begin
                stage[i] <= DEFAULT_THRESH;
            end
            dirty   <= '1;
            pending <= 1'b1;
            loaded  <= 1'b0;
        end else begin
            for (int i = 0; i < NBEAMS; i++) begin
                if (hit[i]) begin
                    stage[i] <= wr_thresh_i;
                end
            end
            dirty   <= dirty_nxt;
            pending <= pending_nxt;
            loaded  <= loaded_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            thresh_o    <= 18'd0;
            thresh_ce_o <= '0;
            update_o    <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            wr_err_o    <= 1'b0;
        end else begin
            thresh_o    <= thresh_nxt;
            thresh_ce_o <= ce_nxt;
            update_o    <= last && loaded;
            busy_o      <= (state_nxt != IDLE);
            done_o      <= last;
            wr_err_o    <= wr_en_i && !wr_ok;
        end
    end

endmodule

// File: tb/tb_beam_threshold_loader.sv
// Self-checking bench for beam_threshold_loader: directed scenarios plus randomized write/commit traffic.
// Expected load sequences come from a per-beam value/changed-flag model of the staging rules.
module tb_beam_threshold_loader;

    localparam int          NB  = 2;
    localparam logic [17:0] DEF = 18'h3FFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [5:0]    wr_beam;
    logic [17:0]   wr_thresh;
    logic          commit;
    logic [17:0]   thresh_o;
    logic [NB-1:0] thresh_ce_o;
    logic          update_o, busy_o, done_o, wr_err_o;

    int checks = 0;
    int errors = 0;

    logic [17:0] m_stage [NB];
    bit          m_dirty [NB];

    beam_threshold_loader #(.NBEAMS(NB), .DEFAULT_THRESH(DEF)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wr_beam_i(wr_beam),
        .wr_thresh_i(wr_thresh), .commit_i(commit), .thresh_o(thresh_o),
        .thresh_ce_o(thresh_ce_o), .update_o(update_o), .busy_o(busy_o),
        .done_o(done_o), .wr_err_o(wr_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        commit = 1'b0;
    endtask

    task automatic model_defaults();
        for (int i = 0; i < NB; i++) begin
            m_stage[i] = DEF;
            m_dirty[i] = 1'b1;
        end
    endtask

    // Called in the cycle where the sequence has just been requested; walks SCAN, UPDATE and the following idle cycle.
    task automatic check_seq(input bit queue_commit, input bit noisy, input string tag);
        bit            rej_prev;
        bit            any;
        logic [NB-1:0] expce;
        logic [2:0]    ctl, exp_ctl;
        rej_prev = 1'b0;
        any      = 1'b0;
        for (int j = 0; j <= NB; j++) begin
            tick();
            checks++;
            if (wr_err_o !== rej_prev) begin
                errors++;
                $display("FAIL %s wr_err cycle %0d: got %b want %b", tag, j, wr_err_o, rej_prev);
            end
            expce = '0;
            if (j < NB && m_dirty[j]) begin
                expce[j] = 1'b1;
                any      = 1'b1;
            end
            checks++;
            if (thresh_ce_o !== expce) begin
                errors++;
                $display("FAIL %s thresh_ce cycle %0d: got %b want %b", tag, j, thresh_ce_o, expce);
            end
            if (j < NB && m_dirty[j]) begin
                checks++;
                if (thresh_o !== m_stage[j]) begin
                    errors++;
                    $display("FAIL %s thresh beam %0d: got %h want %h", tag, j, thresh_o, m_stage[j]);
                end
            end
            ctl     = {busy_o, update_o, done_o};
            exp_ctl = (j < NB) ? 3'b100 : {1'b1, any, 1'b1};
            checks++;
            if (ctl !== exp_ctl) begin
                errors++;
                $display("FAIL %s busy/update/done cycle %0d: got %b want %b", tag, j, ctl, exp_ctl);
            end
            rej_prev = 1'b0;
            if (queue_commit && j == 0) commit = 1'b1;
            if (noisy) begin
                wr_en     = 1'b1;
                wr_beam   = 6'($urandom_range(0, NB - 1));
                wr_thresh = 18'($urandom);
                rej_prev  = 1'b1;
            end
        end
        for (int i = 0; i < NB; i++) m_dirty[i] = 1'b0;
        tick();
        ctl = {busy_o, update_o, done_o};
        checks++;
        if (ctl !== 3'b000 || thresh_ce_o !== '0) begin
            errors++;
            $display("FAIL %s after-seq busy/update/done/ce: got %b/%b want 000/0", tag, ctl, thresh_ce_o);
        end
        checks++;
        if (wr_err_o !== rej_prev) begin
            errors++;
            $display("FAIL %s after-seq wr_err: got %b want %b", tag, wr_err_o, rej_prev);
        end
    endtask

    task automatic do_write(input int beam, input logic [17:0] val, input bit with_commit, input string tag);
        logic exp_err;
        exp_err   = (beam >= NB);
        wr_en     = 1'b1;
        wr_beam   = 6'(beam);
        wr_thresh = val;
        commit    = with_commit;
        tick();
        checks++;
        if (wr_err_o !== exp_err || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s write beam %0d wr_err/busy: got %b/%b want %b/0", tag, beam, wr_err_o, busy_o, exp_err);
        end
        if (beam < NB) begin
            m_stage[beam] = val;
            m_dirty[beam] = 1'b1;
        end
    endtask

    task automatic do_commit(input bit noisy, input string tag);
        commit = 1'b1;
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s busy in commit cycle: got %b want 0", tag, busy_o);
        end
        check_seq(1'b0, noisy, tag);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({thresh_o, thresh_ce_o, update_o, busy_o, done_o, wr_err_o} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got %h/%b/%b%b%b%b want all zero",
                     thresh_o, thresh_ce_o, update_o, busy_o, done_o, wr_err_o);
        end
        tick();
        tick();
        checks++;
        if ({thresh_o, thresh_ce_o, update_o, busy_o, done_o, wr_err_o} !== '0) begin
            errors++;
            $display("FAIL reset held outputs: got %h/%b/%b%b%b%b want all zero",
                     thresh_o, thresh_ce_o, update_o, busy_o, done_o, wr_err_o);
        end
    endtask

    task automatic test_autoload();
        model_defaults();
        rst_n = 1'b1;
        check_seq(1'b0, 1'b0, "autoload");
    endtask

    task automatic test_sparse();
        do_write(1, 18'h01234, 1'b0, "sparse");
        do_commit(1'b0, "sparse");
    endtask

    task automatic test_empty();
        do_commit(1'b0, "empty");
    endtask

    task automatic test_reject_range();
        do_write(5, 18'h00155, 1'b0, "range");
        do_commit(1'b0, "range_commit");
    endtask

    task automatic test_reject_busy();
        do_write(0, 18'h2A5A5, 1'b1, "busy_wr");
        check_seq(1'b0, 1'b1, "busy_wr");
        do_commit(1'b0, "busy_after");
    endtask

    task automatic test_queued();
        logic [17:0] v;
        do_write(1, 18'h0BEEF, 1'b1, "queued1");
        check_seq(1'b1, 1'b0, "queued1");
        v         = 18'($urandom);
        wr_en     = 1'b1;
        wr_beam   = 6'd0;
        wr_thresh = v;
        m_stage[0] = v;
        m_dirty[0] = 1'b1;
        check_seq(1'b0, 1'b0, "queued2");
    endtask

    task automatic test_mid_reset();
        do_write(0, 18'h12345, 1'b1, "midrst");
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({thresh_o, thresh_ce_o, update_o, busy_o, done_o, wr_err_o} !== '0) begin
            errors++;
            $display("FAIL midrst async clear: got %h/%b/%b%b%b%b want all zero",
                     thresh_o, thresh_ce_o, update_o, busy_o, done_o, wr_err_o);
        end
        tick();
        checks++;
        if (update_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst held update/busy: got %b/%b want 0/0", update_o, busy_o);
        end
        model_defaults();
        rst_n = 1'b1;
        check_seq(1'b0, 1'b0, "midrst_reload");
    endtask

    task automatic test_random();
        int nw;
        bit merged;
        for (int it = 0; it < 25; it++) begin
            nw     = $urandom_range(0, 3);
            merged = 1'b0;
            for (int w = 0; w < nw; w++) begin
                merged = (w == nw - 1) && ($urandom_range(0, 1) == 1);
                do_write($urandom_range(0, 3), 18'($urandom), merged, "rand");
            end
            if (merged) check_seq(1'b0, 1'($urandom_range(0, 1)), "rand");
            else        do_commit(1'($urandom_range(0, 1)), "rand");
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_beam   = 6'd0;
        wr_thresh = 18'd0;
        commit    = 1'b0;
        test_reset();
        test_autoload();
        test_sparse();
        test_empty();
        test_reject_range();
        test_reject_busy();
        test_queued();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
